// File: rtl/receptor_display_spi.sv
// receptor_display_spi: SPI-slave model of the OLED display link.
// Oversamples io_sclk/io_sdin/io_cs/io_dc/io_reset in the clk domain, builds
// MSB-first bytes, tags each byte as command (dc=0) or data (dc=1) and gives
// each data byte its index within a frame.
//
// Pipeline from a raw io_sclk rise to rx_valid is four clk edges:
// sync flop 1, sync flop 2, registered rise detect, output register.
//
// Handshake: rx_valid, frame_done and frame_err are single-cycle pulses with
// no back-pressure. rx_byte/rx_dc/data_addr are valid in the rx_valid cycle
// and hold their values until the next byte or rst_n.
module receptor_display_spi #(
  parameter int FRAME_BYTES = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_sclk,
  input  logic              io_sdin,
  input  logic              io_cs,
  input  logic              io_dc,
  input  logic              io_reset,
  output logic [7:0]        rx_byte,
  output logic              rx_dc,
  output logic              rx_valid,
  output logic [ADDR_W-1:0] data_addr,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t state_q, state_d;

  logic [1:0] sclk_sync, sdin_sync, cs_sync, dc_sync, rst_sync;
  logic       sclk_s, sdin_s, cs_s, dc_s, disp_rst_n_s;
  logic       sclk_d, rise_r, bit_r, dc_r;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic [7:0] sr_next;
  logic [ADDR_W-1:0] addr_cnt;
  logic       take_bit, err_set;

  assign sclk_s       = sclk_sync[1];
  assign sdin_s       = sdin_sync[1];
  assign cs_s         = cs_sync[1];
  assign dc_s         = dc_sync[1];
  assign disp_rst_n_s = rst_sync[1];
  assign sr_next      = {sr[6:0], bit_r};

  // Two-flop synchronizers; reset to the link's idle levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      sdin_sync <= 2'b00;
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      rst_sync  <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[0], io_sclk};
      sdin_sync <= {sdin_sync[0], io_sdin};
      cs_sync   <= {cs_sync[0], io_cs};
      dc_sync   <= {dc_sync[0], io_dc};
      rst_sync  <= {rst_sync[0], io_reset};
    end
  end

  // Registered rise detect; sdin/dc are captured alongside so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      rise_r <= 1'b0;
      bit_r  <= 1'b0;
      dc_r   <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      rise_r <= sclk_s & ~sclk_d;
      if (sclk_s & ~sclk_d) begin
        bit_r <= sdin_s;
        dc_r  <= dc_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control: display reset wins, then cs, then sclk.
  always_comb begin
    state_d  = state_q;
    take_bit = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (disp_rst_n_s && !cs_s) state_d = RECV;
      end
      RECV: begin
        if (!disp_rst_n_s) begin
          state_d = IDLE;
        end else if (cs_s) begin
          state_d = IDLE;
          err_set = (bit_cnt != 3'd0);
        end else begin
          take_bit = rise_r;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit counter, frame address and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 3'd0;
      sr         <= 8'h00;
      addr_cnt   <= '0;
      rx_byte    <= 8'h00;
      rx_dc      <= 1'b0;
      rx_valid   <= 1'b0;
      data_addr  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= err_set;
      if (!disp_rst_n_s) begin
        bit_cnt  <= 3'd0;
        addr_cnt <= '0;
      end else if (state_q == IDLE) begin
        bit_cnt <= 3'd0;
      end else if (err_set) begin
        bit_cnt <= 3'd0;
      end else if (take_bit) begin
        sr      <= sr_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte  <= sr_next;
          rx_dc    <= dc_r;
          rx_valid <= 1'b1;
          if (dc_r) begin
            data_addr <= addr_cnt;
            if (addr_cnt == LAST_ADDR) begin
              frame_done <= 1'b1;
              addr_cnt   <= '0;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
            end
          end else begin
            data_addr <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_receptor_display_spi.sv
// tb_receptor_display_spi: directed test of the display SPI receiver.
module tb_receptor_display_spi;

  localparam int W = 20;  // {frame_done, dc, addr[9:0], byte[7:0]}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       io_sclk = 1'b0, io_sdin = 1'b0, io_cs = 1'b1, io_dc = 1'b0, io_reset = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_dc, rx_valid, frame_done, frame_err;
  logic [9:0] data_addr;

  receptor_display_spi #(.FRAME_BYTES(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs), .io_dc(io_dc), .io_reset(io_reset),
    .rx_byte(rx_byte), .rx_dc(rx_dc), .rx_valid(rx_valid), .data_addr(data_addr),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int unsigned  obs_cyc_q[$];
  logic [W-1:0] last_obs;
  int unsigned  last_obs_cyc;
  int unsigned  rise_cyc;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           err_cnt = 0;
  int           valid_cnt = 0;
  int           model_addr = 0;

  // monitor: sample outputs on the falling edge
  always @(negedge clk) begin
    if (rx_valid) begin
      obs_q.push_back({frame_done, rx_dc, data_addr, rx_byte});
      obs_cyc_q.push_back(cyc);
      valid_cnt++;
    end
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: one SPI bit, sclk low 3 clk then high 3 clk
  task automatic send_bit(input logic b, input logic dc);
    @(negedge clk);
    io_sclk = 1'b0;
    io_sdin = b;
    io_dc   = dc;
    wait_clk(3);
    io_sclk  = 1'b1;
    rise_cyc = cyc;
    wait_clk(3);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i], dc);
  endtask

  // reference model for the expected record of a full byte
  task automatic send_byte(input logic [7:0] b, input logic dc);
    logic [9:0] a;
    logic       fd;
    a  = 10'd0;
    fd = 1'b0;
    if (dc) begin
      a  = 10'(model_addr);
      fd = (model_addr == 1023);
      model_addr = fd ? 0 : model_addr + 1;
    end
    exp_q.push_back({fd, dc, a, b});
    send_bits(b, dc, 8);
  endtask

  // pop one received record (bounded wait) and compare with the model
  task automatic check_rx(input string tag);
    logic [W-1:0] e;
    int t;
    t = 0;
    while (obs_q.size() == 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      last_obs     = obs_q.pop_front();
      last_obs_cyc = obs_cyc_q.pop_front();
      check(tag, 32'(last_obs), 32'(e));
    end
  endtask

  initial begin
    int v0, e0;

    // reset
    wait_clk(3);
    check("reset_outputs", {rx_byte, rx_dc, rx_valid, data_addr, frame_done, frame_err}, 32'd0);
    rst_n = 1'b1;
    wait_clk(3);

    // 1: command 0xAE with latency check
    io_cs = 1'b0;
    wait_clk(4);
    send_byte(8'hAE, 1'b0);
    check_rx("t1_cmd");
    check("t1_byte", last_obs[7:0], 32'hAE);
    check("t1_dc_addr", last_obs[19:8], 32'h000);
    check("t1_latency", last_obs_cyc - rise_cyc, 32'd4);

    // 2: one full frame plus two bytes
    for (int k = 0; k < 1026; k++) begin
      send_byte(8'(k), 1'b1);
      check_rx("t2_data");
      if (k == 1023) check("t2_frame_done_1023", last_obs[19], 32'd1);
      if (k == 1022) check("t2_no_frame_done_1022", last_obs[19], 32'd0);
      if (k == 1024) check("t2_wrap_addr", last_obs[17:8], 32'd0);
      if (k == 1025) check("t2_addr_after_wrap", last_obs[17:8], 32'd1);
    end

    // 3: partial byte then cs high
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(8'hF0, 1'b1, 5);
    io_cs = 1'b1;
    wait_clk(8);
    check("t3_frame_err", err_cnt - e0, 32'd1);
    check("t3_no_valid", valid_cnt - v0, 32'd0);
    io_cs = 1'b0;
    wait_clk(4);
    send_byte(8'h55, 1'b1);
    check_rx("t3_after_err");
    check("t3_byte", last_obs[7:0], 32'h55);

    // 4: display reset mid-frame
    for (int k = 0; k < 10; k++) begin
      send_byte(8'(8'hA0 + k), 1'b1);
      check_rx("t4_data");
    end
    e0 = err_cnt;
    @(negedge clk);
    io_reset = 1'b0;
    wait_clk(10);
    io_reset = 1'b1;
    model_addr = 0;
    wait_clk(4);
    send_byte(8'h3C, 1'b1);
    check_rx("t4_after_reset");
    check("t4_addr", last_obs[17:8], 32'd0);
    check("t4_no_err", err_cnt - e0, 32'd0);

    // 5: command bytes do not advance the address
    @(negedge clk);
    io_reset = 1'b0;
    wait_clk(4);
    io_reset = 1'b1;
    model_addr = 0;
    wait_clk(4);
    send_byte(8'h01, 1'b1); check_rx("t5_d01"); check("t5_addr0", last_obs[17:8], 32'd0);
    send_byte(8'h02, 1'b1); check_rx("t5_d02"); check("t5_addr1", last_obs[17:8], 32'd1);
    send_byte(8'h21, 1'b0); check_rx("t5_c21"); check("t5_cmd", last_obs[18:8], 32'd0);
    send_byte(8'h03, 1'b1); check_rx("t5_d03"); check("t5_addr2", last_obs[17:8], 32'd2);

    // 6: rst_n during bit 4
    e0 = err_cnt;
    send_bits(8'hFF, 1'b1, 4);
    @(negedge clk);
    io_sclk = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_outputs_cleared", {rx_byte, rx_dc, rx_valid, data_addr, frame_done, frame_err}, 32'd0);
    wait_clk(3);
    rst_n = 1'b1;
    model_addr = 0;
    wait_clk(6);
    send_byte(8'hC3, 1'b1);
    check_rx("t6_clean_byte");
    check("t6_no_err", err_cnt - e0, 32'd0);

    io_cs = 1'b1;
    wait_clk(10);
    check("end_no_extra_valid", obs_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
